// File: rtl/entrada_debounce.sv
// Sync + debounce of enter, one-word capture buffer handed to the IN stage by req/ack; capture lands 2+DEBOUNCE_CYCLES+1 cycles after a clean press.
// A press that finds the buffer full is dropped and sets sticky overrun. Define ENTRADA_AUTOREPEAT_EN for hold-to-repeat captures.
module entrada_debounce #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter_raw,
  input  logic [WIDTH-1:0] entrada_raw,
  input  logic             in_req,
  output logic [WIDTH-1:0] valor,
  output logic             pendente,
  output logic             sinal,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_PRESS_CNT   = 2'd1;
  localparam logic [1:0] S_PRESSED     = 2'd2;
  localparam logic [1:0] S_RELEASE_CNT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W))
      $error("DEBOUNCE_CYCLES-1 does not fit in CNT_W bits");
    if (REPEAT_CYCLES < 1)
      $error("REPEAT_CYCLES must be at least 1");
  endgenerate

  logic             r_enter_s1, r_enter_s;
  logic [WIDTH-1:0] r_entrada_s1, r_entrada_s;
  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_pressed, w_deb_capture, w_rep_fire, w_capture, w_consume;
  logic [WIDTH-1:0] r_valor;
  logic             r_pendente, r_sinal, r_overrun;

  // Sync flops come out of reset in the released (high) state for enter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_enter_s1   <= 1'b1;
      r_enter_s    <= 1'b1;
      r_entrada_s1 <= '0;
      r_entrada_s  <= '0;
    end else begin
      r_enter_s1   <= enter_raw;
      r_enter_s    <= r_enter_s1;
      r_entrada_s1 <= entrada_raw;
      r_entrada_s  <= r_entrada_s1;
    end
  end

  assign w_pressed = ~r_enter_s;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_deb_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pressed) begin
          w_state_nxt = S_PRESS_CNT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_CNT: begin
        if (!w_pressed) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = S_PRESSED;
          w_deb_capture = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!w_pressed) begin
          w_state_nxt = S_RELEASE_CNT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (w_pressed) begin
          w_state_nxt = S_PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef ENTRADA_AUTOREPEAT_EN
  localparam int RCNT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] REP_LAST = RCNT_W'(REPEAT_CYCLES - 1);

  logic [RCNT_W-1:0] r_rep_cnt;

  assign w_rep_fire = (r_state == S_PRESSED) && (r_rep_cnt == REP_LAST);

  // Only counts while held; any excursion out of PRESSED restarts the period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rep_cnt <= '0;
    end else if (r_state != S_PRESSED || w_rep_fire) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + RCNT_W'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign w_capture = w_deb_capture | w_rep_fire;
  // The sinal guard keeps a still-high in_req from double-consuming one word.
  assign w_consume = r_pendente & in_req & ~r_sinal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valor    <= '0;
      r_pendente <= 1'b0;
      r_sinal    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sinal <= w_consume;
      if (w_capture) begin
        if (!r_pendente || w_consume) begin
          r_valor    <= r_entrada_s;
          r_pendente <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_consume) begin
        r_pendente <= 1'b0;
      end
    end
  end

  assign valor    = r_valor;
  assign pendente = r_pendente;
  assign sinal    = r_sinal;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_entrada_debounce.sv
// Directed bench for entrada_debounce (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20); consumed words go through a scoreboard queue.
module tb_entrada_debounce;
  localparam int WIDTH = 18;

  logic             clock;
  logic             reset;
  logic             enter_raw;
  logic [WIDTH-1:0] entrada_raw;
  logic             in_req;
  logic [WIDTH-1:0] valor;
  logic             pendente;
  logic             sinal;
  logic             overrun;

  int n_chk;
  int n_pass;
  int n_pulses;
  int pulses_before;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] cons_word;
  logic [WIDTH-1:0] exp_word;

  entrada_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .REPEAT_CYCLES(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enter_raw(enter_raw),
    .entrada_raw(entrada_raw),
    .in_req(in_req),
    .valor(valor),
    .pendente(pendente),
    .sinal(sinal),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Word seen on valor during the handshake cycle is what the processor takes.
  always @(negedge clock) begin
    if (reset) begin
      if (sinal) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_sinal: got pulse with word %h, expected no pulse", cons_word);
        end else begin
          exp_word = exp_q.pop_front();
          chk("consume_word", 32'(cons_word), 32'(exp_word));
        end
      end
      if (pendente && in_req && !sinal) cons_word = valor;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic press_capture(input logic [WIDTH-1:0] w);
    entrada_raw = w;
    tick(3);
    enter_raw = 1'b0;
    tick(7);
  endtask

  task automatic release_settle();
    enter_raw = 1'b1;
    tick(10);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_pulses = 0;
    cons_word = '0;
    reset = 1'b0; enter_raw = 1'b1; entrada_raw = '0; in_req = 1'b0;
    #2;
    chk("rst_valor", 32'(valor), 32'h0);
    chk("rst_pendente", 32'(pendente), 32'h0);
    chk("rst_sinal", 32'(sinal), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    tick(3);
    reset = 1'b1;
    tick(2);

    // 1: clean press, exact latency, then handshake
    entrada_raw = 18'h2A5A5;
    tick(3);
    enter_raw = 1'b0;
    tick(6);
    chk("t1_pend_before_latency", 32'(pendente), 32'h0);
    tick(1);
    chk("t1_pend_at_latency", 32'(pendente), 32'h1);
    chk("t1_valor", 32'(valor), 32'h2A5A5);
    chk("t1_sinal_idle", 32'(sinal), 32'h0);
    tick(13);
    release_settle();
    exp_q.push_back(18'h2A5A5);
    in_req = 1'b1;
    tick(1);
    chk("t1_sinal_pulse", 32'(sinal), 32'h1);
    chk("t1_pend_cleared", 32'(pendente), 32'h0);
    tick(1);
    chk("t1_sinal_one_cycle", 32'(sinal), 32'h0);
    in_req = 1'b0;
    tick(2);

    // 2: bouncing enter never captures
    for (int i = 0; i < 8; i++) begin
      enter_raw = i[0];
      tick(2);
    end
    enter_raw = 1'b1;
    tick(10);
    chk("t2_no_capture", 32'(pendente), 32'h0);
    chk("t2_no_overrun", 32'(overrun), 32'h0);

    // 3: second press while full is dropped
    press_capture(18'h00001);
    chk("t3_first_capture", 32'(valor), 32'h00001);
    release_settle();
    press_capture(18'h00002);
    chk("t3_valor_held", 32'(valor), 32'h00001);
    chk("t3_overrun_set", 32'(overrun), 32'h1);
    chk("t3_pend_still", 32'(pendente), 32'h1);
    release_settle();
    exp_q.push_back(18'h00001);
    in_req = 1'b1;
    tick(1);
    chk("t3_sinal", 32'(sinal), 32'h1);
    chk("t3_pend_cleared", 32'(pendente), 32'h0);
    chk("t3_overrun_sticky", 32'(overrun), 32'h1);
    in_req = 1'b0;
    tick(2);

    reset = 1'b0;
    #1;
    chk("rst_clears_overrun", 32'(overrun), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // 4: capture lands in the same cycle as a consume
    press_capture(18'h00011);
    release_settle();
    entrada_raw = 18'h00022;
    tick(3);
    enter_raw = 1'b0;
    tick(6);
    in_req = 1'b1;
    exp_q.push_back(18'h00011);
    tick(1);
    chk("t4_sinal", 32'(sinal), 32'h1);
    chk("t4_pend_stays", 32'(pendente), 32'h1);
    chk("t4_valor_new", 32'(valor), 32'h00022);
    chk("t4_no_overrun", 32'(overrun), 32'h0);
    in_req = 1'b0;
    enter_raw = 1'b1;
    tick(1);
    chk("t4_sinal_one_cycle", 32'(sinal), 32'h0);
    exp_q.push_back(18'h00022);
    in_req = 1'b1;
    tick(1);
    chk("t4_second_sinal", 32'(sinal), 32'h1);
    chk("t4_pend_cleared", 32'(pendente), 32'h0);
    in_req = 1'b0;
    tick(10);

    // 5: reset mid-debounce and with a word pending
    entrada_raw = 18'h00033;
    tick(3);
    enter_raw = 1'b0;
    tick(4);
    reset = 1'b0;
    #1;
    chk("t5_rst_mid_pend", 32'(pendente), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(6);
    chk("t5_pend_before_latency", 32'(pendente), 32'h0);
    tick(1);
    chk("t5_capture_after_rst", 32'(pendente), 32'h1);
    chk("t5_valor", 32'(valor), 32'h00033);
    reset = 1'b0;
    #1;
    chk("t5_async_pend", 32'(pendente), 32'h0);
    chk("t5_async_valor", 32'(valor), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(7);
    chk("t5_recapture", 32'(valor), 32'h00033);
    release_settle();
    exp_q.push_back(18'h00033);
    in_req = 1'b1;
    tick(1);
    chk("t5_sinal", 32'(sinal), 32'h1);
    in_req = 1'b0;
    tick(2);

    // 6: long hold with in_req high
    entrada_raw = 18'h0003C;
    tick(3);
    in_req = 1'b1;
    tick(3);
    chk("t6_req_without_word", 32'(sinal), 32'h0);
    pulses_before = n_pulses;
`ifdef ENTRADA_AUTOREPEAT_EN
    repeat (4) exp_q.push_back(18'h0003C);
`else
    exp_q.push_back(18'h0003C);
`endif
    enter_raw = 1'b0;
    tick(70);
    enter_raw = 1'b1;
    tick(12);
    in_req = 1'b0;
`ifdef ENTRADA_AUTOREPEAT_EN
    chk("t6_pulse_count", 32'(n_pulses - pulses_before), 32'd4);
`else
    chk("t6_pulse_count", 32'(n_pulses - pulses_before), 32'd1);
`endif
    chk("t6_no_overrun", 32'(overrun), 32'h0);
    chk("t6_pend_drained", 32'(pendente), 32'h0);
    tick(2);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/entrada_debounce.md
Name: entrada_debounce

Overview:
Upstream front end for the processor's IN path. Synchronizes the raw enter pushbutton and the 18 input switches, debounces enter, and captures one switch word per clean press. It then hands that word to the processor's input stage with a single-entry req/ack handshake. It sits between the board pins and the input-data block, replacing direct use of the raw enter signal.

Parameters:
WIDTH, 18, switch word width
DEBOUNCE_CYCLES, 50000, clock cycles enter must be stable before a press/release is accepted (1 ms at 50 MHz)
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
REPEAT_CYCLES, 25000000, hold time between auto-repeat captures (used only with ENTRADA_AUTOREPEAT_EN)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
enter_raw  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clock
entrada_raw  input  WIDTH  raw switches, asynchronous to clock
in_req  input  1  level from processor: IN instruction waiting for data
valor  output  WIDTH  captured word; stable while pendente=1
pendente  output  1  a captured word is waiting to be consumed
sinal  output  1  one-cycle pulse: word on valor consumed this cycle
overrun  output  1  sticky: a press was dropped because the buffer was full

Behaviour:
- Reset (reset=0, async): FSM=IDLE; counter=0; sync flops=released/0; valor=0, pendente=0, sinal=0, overrun=0.
- Synchronizer: enter_raw and entrada_raw each pass through 2 flops. Only the synchronized copies (enter_s, entrada_s) are used. Pressed means enter_s==0.
- Debounce FSM, with counter cnt:
  - IDLE (released, stable): on pressed -> PRESS_CNT, cnt=0.
  - PRESS_CNT: if released -> IDLE (bounce). Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED and fire capture. Else cnt++.
  - PRESSED: on released -> RELEASE_CNT, cnt=0.
  - RELEASE_CNT: if pressed -> PRESSED with no new capture. Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt++.
- Capture, on the transition into PRESSED from PRESS_CNT:
  - If pendente==0, or a consume happens in the same cycle: valor<=entrada_s, pendente<=1.
  - Otherwise valor is held, the new word is dropped, and overrun<=1.
- Capture latency: enter_raw falling edge at cycle 0 → pendente=1 at cycle 2+DEBOUNCE_CYCLES+1, provided enter_raw is stable throughout.
- Handshake:
  - Consume fires when pendente==1 && in_req==1 && sinal==0.
  - Next cycle: sinal=1 for exactly one cycle, pendente=0 (unless a same-cycle capture reloads it), valor unchanged.
  - in_req held high with no pendente has no effect; sinal stays 0.
  - in_req is not required to drop between words. The sinal==0 guard limits consumes to one per two cycles at most.
- Simultaneous consume and capture: the old word is consumed (sinal=1), the new word is loaded, pendente stays 1, overrun is unchanged.
- overrun clears only on reset.
- Counter never wraps; it saturates at DEBOUNCE_CYCLES-1 via the transition.
- Switch changes while pendente=1 never alter valor.
- Reset asserted mid-debounce or mid-handshake: all state clears immediately. A press still held at release of reset needs a full PRESS_CNT debounce before it captures.

Optional Feature:
ENTRADA_AUTOREPEAT_EN
- Defined: while in PRESSED, a second counter runs. Each time it reaches REPEAT_CYCLES-1 it reloads to 0 and fires a capture with the same buffer and overrun rules. Leaving PRESSED clears the counter.
- Undefined: no repeat counter is synthesized; exactly one capture per debounced press.

Test Plan (sim with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20):
1. entrada_raw=18'h2A5A5, clean press held 20 cycles, in_req=0 → pendente=1 exactly 7 cycles after the press edge, valor=18'h2A5A5, sinal=0; then in_req=1 → sinal pulses 1 cycle, pendente=0 the same cycle.
2. Bounce: enter_raw toggles low/high every 2 cycles for 16 cycles, then high → no capture, pendente=0, FSM returns to IDLE.
3. Overrun: press with 18'h00001, release, then press with 18'h00002, no in_req → valor=18'h00001, overrun=1; consume → sinal=1, pendente=0, overrun stays 1.
4. Simultaneous: press debounce completing in the same cycle as the consume of a pending 18'h00011, new word 18'h00022 → sinal=1, pendente stays 1, valor=18'h00022, overrun=0.
5. Reset mid-operation: reset=0 during PRESS_CNT and again with pendente=1 → all outputs 0 immediately (async); press held through reset release captures 7 cycles after reset rises.
6. ENTRADA_AUTOREPEAT_EN defined, press held 70 cycles with in_req=1 → 1 initial capture + 3 repeat captures, 4 sinal pulses total, overrun=0.
